// File: rtl/bus_arbiter_ctrl_pkg.sv
// Shared definitions for the CPU/DMA data-bus arbiter: FSM encoding, device select codes and
// default parameters.
package bus_arbiter_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMemAcc,
    StMemResp,
    StIoAcc,
    StResp
  } arb_state_e;

  typedef enum logic {
    NowDeviceMem = 1'b0,
    NowDeviceIo  = 1'b1
  } now_device_e;

  typedef enum logic {
    GntCpu = 1'b0,
    GntDma = 1'b1
  } gnt_e;

  localparam logic [15:0] IoBaseDefault    = 16'h7F00;
  localparam logic [7:0]  IoTimeoutDefault = 8'd255;

endpackage

// File: rtl/bus_arbiter_ctrl_if.sv
// Bundle of the CPU, DMA, data-memory and IO bus signals around the arbiter.
// slave: the arbiter's view; master: the surrounding requesters and devices.
interface bus_arbiter_ctrl_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_ack;
  logic [31:0] dma_rdata;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        io_en;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ready;

  logic        bus_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_stall, cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    output dma_ack, dma_rdata,
    output mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output io_en, io_we, io_be, io_addr, io_wdata,
    input  io_rdata, io_ready,
    output bus_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_stall, cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_be,
    input  dma_ack, dma_rdata,
    input  mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  io_en, io_we, io_be, io_addr, io_wdata,
    output io_rdata, io_ready,
    input  bus_err
  );

endinterface

// File: rtl/bus_arbiter_ctrl_dev_decode.sv
// Address decoder: the upper address half equal to IO_BASE selects the IO bus, anything else
// goes to data memory. Kept standalone so the M-stage control can reuse it.
module dev_decode
  import bus_arbiter_ctrl_pkg::*;
#(
  parameter logic [15:0] IO_BASE = IoBaseDefault
) (
  input  logic [31:0] addr_i,
  output now_device_e now_device_o
);

  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_i[15:0];

  assign now_device_o = (addr_i[31:16] == IO_BASE) ? NowDeviceIo : NowDeviceMem;

endmodule

// File: rtl/bus_arbiter_ctrl.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a single-cycle data memory and a
// ready-handshaked IO bus with timeout.
module bus_arbiter_ctrl
  import bus_arbiter_ctrl_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = IoBaseDefault,
  parameter logic [7:0]  IO_TIMEOUT = IoTimeoutDefault
) (
  input logic               clk,
  input logic               reset_n,
  bus_arbiter_ctrl_if.slave bus_io
);

  arb_state_e  state_q, state_d;
  gnt_e        gnt_q, gnt_d;
  gnt_e        last_gnt_q, last_gnt_d;
  gnt_e        sel_gnt;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] sel_addr;
  now_device_e sel_dev;
  logic        cpu_ack, dma_ack;

  // On a tie the port that was not favoured last time wins; last_gnt starts at DMA so the
  // CPU wins the first tie after reset.
  always_comb begin
    if (bus_io.cpu_req && bus_io.dma_req) begin
      sel_gnt = (last_gnt_q == GntDma) ? GntCpu : GntDma;
    end else if (bus_io.cpu_req) begin
      sel_gnt = GntCpu;
    end else begin
      sel_gnt = GntDma;
    end
    sel_addr = (sel_gnt == GntDma) ? bus_io.dma_addr : bus_io.cpu_addr;
  end

  dev_decode #(
    .IO_BASE(IO_BASE)
  ) u_dev_decode (
    .addr_i      (sel_addr),
    .now_device_o(sel_dev)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.cpu_req || bus_io.dma_req) begin
          gnt_d      = sel_gnt;
          last_gnt_d = (last_gnt_q == GntCpu) ? GntDma : GntCpu;
          addr_d     = sel_addr;
          we_d       = (sel_gnt == GntDma) ? bus_io.dma_we    : bus_io.cpu_we;
          wdata_d    = (sel_gnt == GntDma) ? bus_io.dma_wdata : bus_io.cpu_wdata;
          be_d       = (sel_gnt == GntDma) ? bus_io.dma_be    : bus_io.cpu_be;
          cnt_d      = '0;
          err_d      = 1'b0;
          rdata_d    = '0;
          state_d    = (sel_dev == NowDeviceIo) ? StIoAcc : StMemAcc;
        end
      end
      StMemAcc: state_d = StMemResp;
      StMemResp: begin
        rdata_d = bus_io.mem_rdata;
        state_d = StResp;
      end
      StIoAcc: begin
        if (bus_io.io_ready) begin
          rdata_d = bus_io.io_rdata;
          state_d = StResp;
        end else if (cnt_q == IO_TIMEOUT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gnt_q      <= GntCpu;
      last_gnt_q <= GntDma;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Bus strobes are decoded from the state register so an async reset clears them at once.
  always_comb begin
    bus_io.mem_we    = 1'b0;
    bus_io.mem_be    = '0;
    bus_io.mem_addr  = '0;
    bus_io.mem_wdata = '0;
    bus_io.io_en     = 1'b0;
    bus_io.io_we     = 1'b0;
    bus_io.io_be     = '0;
    bus_io.io_addr   = '0;
    bus_io.io_wdata  = '0;
    if (state_q == StMemAcc) begin
      bus_io.mem_we    = we_q;
      bus_io.mem_be    = be_q;
      bus_io.mem_addr  = addr_q;
      bus_io.mem_wdata = wdata_q;
    end
    if (state_q == StIoAcc) begin
      bus_io.io_en    = 1'b1;
      bus_io.io_we    = we_q;
      bus_io.io_be    = be_q;
      bus_io.io_addr  = addr_q;
      bus_io.io_wdata = wdata_q;
    end
  end

  assign cpu_ack          = (state_q == StResp) && (gnt_q == GntCpu);
  assign dma_ack          = (state_q == StResp) && (gnt_q == GntDma);
  assign bus_io.cpu_ack   = cpu_ack;
  assign bus_io.dma_ack   = dma_ack;
  assign bus_io.cpu_rdata = cpu_ack ? rdata_q : '0;
  assign bus_io.dma_rdata = dma_ack ? rdata_q : '0;
  assign bus_io.cpu_stall = bus_io.cpu_req & ~cpu_ack;
  assign bus_io.bus_err   = (state_q == StResp) & err_q;

endmodule

// File: doc/bus_arbiter_ctrl.md
BUS_ARBITER_CTRL -- requirements
Module: bus_arbiter_ctrl

Interface
REQ-001 SHALL: parameter IO_BASE, default 16'h7F00, upper address half that selects IO.
REQ-002 SHALL: parameter IO_TIMEOUT, default 8'd255, maximum wait cycles for io_ready.
REQ-003 SHALL: clk  in  1  single clock, rising edge; reset is asynchronous and active-low.
REQ-004 SHALL: reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL: cpu_req/cpu_we  in  1/1  M-stage access request/write; held stable until cpu_ack.
REQ-006 SHALL: cpu_addr/cpu_wdata  in  32/32  CPU address/store data.
REQ-007 SHALL: cpu_be  in  4  CPU byte enables.
REQ-008 SHALL: cpu_stall/cpu_ack  out  1/1  pipeline freeze / one-cycle completion.
REQ-009 SHALL: cpu_rdata  out  32  CPU load data, valid with cpu_ack.
REQ-010 SHALL: dma_req, dma_we, dma_addr, dma_wdata, dma_be, dma_ack, dma_rdata: same widths/meaning as CPU port.
REQ-011 SHALL: mem_we/mem_be/mem_addr/mem_wdata  out  1/4/32/32  data-memory port; mem_rdata  in  32, valid one cycle after address.
REQ-012 SHALL: io_en/io_we/io_be/io_addr/io_wdata  out  1/1/4/32/32  IO bus; io_rdata  in  32; io_ready  in  1.
REQ-013 SHALL: bus_err  out  1  pulses with ack on IO timeout.

Function
REQ-014 SHALL: states IDLE, MEM_ACC, MEM_RESP, IO_ACC, RESP.
REQ-015 SHALL: IDLE with any request: grant, latch requester, addr, wdata, be, we; select device (addr[31:16]==IO_BASE -> IO, else MEM); next MEM_ACC or IO_ACC.
REQ-016 SHALL: simultaneous requests resolved round-robin; last_gnt flag toggles on each grant; after reset CPU wins first.
REQ-017 SHALL: MEM_ACC drives latched addr/be/wdata for one cycle, mem_we=latched we; next MEM_RESP.
REQ-018 SHALL: MEM_RESP captures mem_rdata into response register; next RESP.
REQ-019 SHALL: IO_ACC holds io_en=1 with latched fields, io_we=latched we; counter increments per cycle; io_ready=1 captures io_rdata -> RESP; counter==IO_TIMEOUT without ready -> rdata=0, err set -> RESP.
REQ-020 SHALL: RESP asserts granted ack for exactly one cycle with rdata; bus_err=err; next IDLE; no grant in RESP.
REQ-021 SHALL: memory read latency req->ack = 4 cycles (IDLE, MEM_ACC, MEM_RESP, RESP); IO = 3 + wait cycles.
REQ-022 SHALL: cpu_stall = cpu_req & ~cpu_ack, combinational.
REQ-023 SHALL: mem_we, io_en, io_we zero outside their states; no write strobe on any other cycle.
REQ-024 SHALL: request dropped before ack is protocol error; access still completes, ack still pulses.
REQ-025 SHALL: loser of arbitration waits; granted on next IDLE entry.

Reset
REQ-026 SHALL: reset_n low: state IDLE, last_gnt=DMA (so CPU first), counter 0, all strobes/acks/bus_err 0, rdata registers 0.
REQ-027 SHALL: reset mid-access aborts immediately; no ack issued afterwards for aborted access.

Structure
REQ-028 SHALL: state encoding, IO_BASE default, NOWDEVICE_MEMO/NOWDEVICE_IO in shared public.v.
REQ-029 SHALL: address decode in sub-module dev_decode (addr -> now_device), reusable by M-stage control.

Verification
REQ-030 SHALL: CPU load at 0x0000_0010, mem_rdata=0xDEADBEEF -> cpu_ack at cycle 4, cpu_rdata=0xDEADBEEF, stall cycles 1-3.
REQ-031 SHALL: CPU store to 0x7F00_0004, wdata 0x5, io_ready after 2 cycles -> io_en/io_we for 3 cycles, one ack, mem_we never 1.
REQ-032 SHALL: both ports request every cycle after reset -> grant order CPU, DMA, CPU, DMA.
REQ-033 SHALL: IO read, io_ready never -> ack at cycle IO_TIMEOUT+3, rdata=0, bus_err=1 one cycle.
REQ-034 SHALL: reset_n low during IO_ACC -> outputs 0 same cycle, no ack after release.
